// File: rtl/branch_pkg.sv
// Shared branch definitions: condition codes, resolve FSM states and the
// condition evaluator used by the branch resolve unit.
package branch_pkg;

    typedef enum logic [2:0] {
        B   = 3'b000,
        BEQ = 3'b001,
        BNE = 3'b010,
        BLT = 3'b011,
        BLE = 3'b100
    } cond_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        UPDATE = 2'd2
    } state_e;

    // Returns {taken, illegal}; unrecognised codes are never taken.
    function automatic logic [1:0] cond_taken(input logic [2:0] cond,
                                              input logic n,
                                              input logic v,
                                              input logic z);
        logic [1:0] r;
        r = 2'b00;
        case (cond_e'(cond))
            B:       r = 2'b10;
            BEQ:     r = {z, 1'b0};
            BNE:     r = {~z, 1'b0};
            BLT:     r = {n ^ v, 1'b0};
            BLE:     r = {(n ^ v) | z, 1'b0};
            default: r = 2'b01;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Branch request channel between the controller FSM (master) and the
// branch resolve unit (slave).
interface branch_resolve_unit_if;
    // A request transfers on a rising edge where br_valid && br_ready; the
    // master holds br_cond/br_imm8 stable while br_valid is high and ready is low.
    // done/taken/illegal form a one-cycle result pulse; taken/illegal are 0 otherwise.
    logic       br_valid;
    logic       br_ready;
    logic [2:0] br_cond;
    logic [7:0] br_imm8;
    logic       done;
    logic       taken;
    logic       illegal;

    modport master (
        output br_valid, br_cond, br_imm8,
        input  br_ready, done, taken, illegal
    );

    modport slave (
        input  br_valid, br_cond, br_imm8,
        output br_ready, done, taken, illegal
    );
endinterface

// File: rtl/branch_resolve_unit_status_reg.sv
// N/V/Z status register with load enable and synchronous reset; shared with
// the datapath.
module status_reg (
    input  logic clk,
    input  logic reset,
    input  logic load_s,
    input  logic n_in,
    input  logic v_in,
    input  logic z_in,
    output logic n_out,
    output logic v_out,
    output logic z_out
);
    always_ff @(posedge clk) begin
        if (reset) begin
            n_out <= 1'b0;
            v_out <= 1'b0;
            z_out <= 1'b0;
        end else if (load_s) begin
            n_out <= n_in;
            v_out <= v_in;
            z_out <= z_in;
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: owns the PC and the status flags, resolves branch
// requests in IDLE -> EVAL -> UPDATE. Optional macro BRANCH_STATS_EN adds a
// saturating taken-branch counter.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_resolve_unit_if.slave br,
    input  logic                 load_s,
    input  logic                 n_in,
    input  logic                 v_in,
    input  logic                 z_in,
    input  logic                 pc_inc,
    output logic [PC_W-1:0]      pc_out,
    output logic                 n_out,
    output logic                 v_out,
    output logic                 z_out,
    output logic [15:0]          taken_count,
    output state_e               dbg_state
);
    state_e          state;
    logic [2:0]      cond_q;
    logic [7:0]      imm_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] target_q;
    logic            taken_q;
    logic            illegal_q;
    logic            done_q;

    logic [1:0]      eval_res;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] imm_ext;
    logic [PC_W-1:0] target;

    status_reg u_status (
        .clk    (clk),
        .reset  (reset),
        .load_s (load_s),
        .n_in   (n_in),
        .v_in   (v_in),
        .z_in   (z_in),
        .n_out  (n_out),
        .v_out  (v_out),
        .z_out  (z_out)
    );

    // Flags are read as registered, so a load landing on the EVAL edge is not seen.
    assign eval_res = cond_taken(cond_q, n_out, v_out, z_out);
    assign pc_plus1 = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign imm_ext  = PC_W'($signed(imm_q));
    assign target   = pc_plus1 + imm_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc_q      <= RESET_PC;
            cond_q    <= 3'b000;
            imm_q     <= 8'h00;
            target_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (br.br_valid) begin
                        cond_q <= br.br_cond;
                        imm_q  <= br.br_imm8;
                        state  <= EVAL;
                    end else if (pc_inc) begin
                        pc_q <= pc_plus1;
                    end
                end
                EVAL: begin
                    taken_q   <= eval_res[1];
                    illegal_q <= eval_res[0];
                    target_q  <= target;
                    done_q    <= 1'b1;
                    state     <= UPDATE;
                end
                UPDATE: begin
                    pc_q  <= taken_q ? target_q : pc_plus1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign br.br_ready = (state == IDLE);
    assign br.done     = done_q;
    assign br.taken    = taken_q;
    assign br.illegal  = illegal_q;
    assign pc_out      = pc_q;
    assign dbg_state   = state;

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt_q <= 16'h0000;
        end else if (done_q && taken_q && (taken_cnt_q != 16'hFFFF)) begin
            taken_cnt_q <= taken_cnt_q + 16'h0001;
        end
    end

    assign taken_count = taken_cnt_q;
`else
    assign taken_count = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (PC_W=9, RESET_PC=0x10).
module tb_branch_resolve_unit;
    import branch_pkg::*;

    localparam int         PC_W     = 9;
    localparam logic [8:0] RST_PC   = 9'h010;

    logic        clk;
    logic        reset;
    logic        load_s;
    logic        n_in, v_in, z_in;
    logic        pc_inc;
    logic [8:0]  pc_out;
    logic        n_out, v_out, z_out;
    logic [15:0] taken_count;
    state_e      dbg_state;

    branch_resolve_unit_if bif ();

    branch_resolve_unit #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .br          (bif.slave),
        .load_s      (load_s),
        .n_in        (n_in),
        .v_in        (v_in),
        .z_in        (z_in),
        .pc_inc      (pc_inc),
        .pc_out      (pc_out),
        .n_out       (n_out),
        .v_out       (v_out),
        .z_out       (z_out),
        .taken_count (taken_count),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state and scoreboard: {taken, illegal, next_pc}
    logic [8:0]  m_pc;
    logic        m_n, m_v, m_z;
    int          m_cnt;
    logic [10:0] exp_q[$];

    function automatic logic [1:0] ref_cond(input logic [2:0] c, input logic n,
                                            input logic v, input logic z);
        case (c)
            3'd0:    return 2'b10;
            3'd1:    return {z, 1'b0};
            3'd2:    return {!z, 1'b0};
            3'd3:    return {n != v, 1'b0};
            3'd4:    return {(n != v) || z, 1'b0};
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [15:0] exp_count();
`ifdef BRANCH_STATS_EN
        return 16'(m_cnt);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        load_s = 1'b0; pc_inc = 1'b0;
        n_in = 1'b0; v_in = 1'b0; z_in = 1'b0;
        bif.br_valid = 1'b0; bif.br_cond = 3'b000; bif.br_imm8 = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        m_pc = RST_PC; m_n = 1'b0; m_v = 1'b0; m_z = 1'b0; m_cnt = 0;
    endtask

    task automatic set_flags(input logic n, input logic v, input logic z);
        load_s = 1'b1; n_in = n; v_in = v; z_in = z;
        tick();
        load_s = 1'b0;
        m_n = n; m_v = v; m_z = z;
    endtask

    task automatic step_to(input logic [8:0] tgt);
        for (int i = 0; i < 512 && m_pc != tgt; i++) begin
            pc_inc = 1'b1;
            tick();
            m_pc = m_pc + 9'd1;
        end
        pc_inc = 1'b0;
        tests_run++;
        if (pc_out !== m_pc) begin
            tests_failed++;
            $display("FAIL step_pc: got %0h expected %0h", pc_out, m_pc);
        end
    endtask

    // Drives one branch and checks its result pulse and the resulting PC.
    task automatic run_branch(input logic [2:0] cond, input logic [7:0] imm,
                              input bit ld_same, input logic [2:0] nvz_same,
                              input bit ld_eval, input logic [2:0] nvz_eval,
                              input bit inc_noise);
        logic [1:0]  r;
        logic [8:0]  tgt, npc;
        logic [10:0] exp;
        bit          seen;
        tests_run++;
        if (bif.br_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL br_ready_idle: got %b expected 1", bif.br_ready);
        end
        bif.br_valid = 1'b1; bif.br_cond = cond; bif.br_imm8 = imm;
        pc_inc = inc_noise;
        load_s = ld_same; {n_in, v_in, z_in} = nvz_same;
        if (ld_same) {m_n, m_v, m_z} = nvz_same;
        r   = ref_cond(cond, m_n, m_v, m_z);
        tgt = m_pc + 9'd1 + {imm[7], imm};
        npc = r[1] ? tgt : m_pc + 9'd1;
        exp_q.push_back({r, npc});
        tick();
        bif.br_valid = 1'b0;
        load_s = ld_eval; {n_in, v_in, z_in} = nvz_eval;
        if (ld_eval) {m_n, m_v, m_z} = nvz_eval;
        tests_run++;
        if (bif.br_ready !== 1'b0 || bif.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL eval_state: got ready=%b done=%b expected ready=0 done=0",
                     bif.br_ready, bif.done);
        end
        tick();
        load_s = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (bif.done === 1'b1) seen = 1'b1;
            else tick();
        end
        exp = exp_q.pop_front();
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL done_timeout: got no done expected done pulse");
        end else begin
            if ({bif.taken, bif.illegal} !== exp[10:9] || pc_out !== m_pc) begin
                tests_failed++;
                $display("FAIL result_pulse: got taken=%b illegal=%b pc=%0h expected taken=%b illegal=%b pc=%0h",
                         bif.taken, bif.illegal, pc_out, exp[10], exp[9], m_pc);
            end
            tick();
            pc_inc = 1'b0;
            m_pc = npc;
            if (r[1] && m_cnt < 65535) m_cnt++;
            tests_run++;
            if (pc_out !== exp[8:0]) begin
                tests_failed++;
                $display("FAIL new_pc: got %0h expected %0h", pc_out, exp[8:0]);
            end
            tests_run++;
            if ({bif.done, bif.taken, bif.illegal} !== 3'b000 || {n_out, v_out, z_out} !== {m_n, m_v, m_z}
                || taken_count !== exp_count() || dbg_state !== IDLE) begin
                tests_failed++;
                $display("FAIL post_update: got dti=%b nvz=%b cnt=%0d st=%0d expected dti=000 nvz=%b cnt=%0d st=0",
                         {bif.done, bif.taken, bif.illegal}, {n_out, v_out, z_out}, taken_count,
                         dbg_state, {m_n, m_v, m_z}, exp_count());
            end
        end
        pc_inc = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (pc_out !== 9'h010 || {n_out, v_out, z_out} !== 3'b000 || bif.br_ready !== 1'b1
            || {bif.done, bif.taken, bif.illegal} !== 3'b000 || taken_count !== 16'h0000
            || dbg_state !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got pc=%0h nvz=%b rdy=%b dti=%b cnt=%0d st=%0d expected pc=10 nvz=000 rdy=1 dti=000 cnt=0 st=0",
                     pc_out, {n_out, v_out, z_out}, bif.br_ready,
                     {bif.done, bif.taken, bif.illegal}, taken_count, dbg_state);
        end
    endtask

    task automatic test_pc_inc();
        for (int i = 0; i < 3; i++) begin
            pc_inc = 1'b1;
            tick();
        end
        pc_inc = 1'b0;
        m_pc = 9'h013;
        tick();
        tests_run++;
        if (pc_out !== 9'h013 || {n_out, v_out, z_out} !== 3'b000 || bif.br_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL pc_inc: got pc=%0h nvz=%b rdy=%b expected pc=13 nvz=000 rdy=1",
                     pc_out, {n_out, v_out, z_out}, bif.br_ready);
        end
    endtask

    task automatic test_beq();
        set_flags(1'b0, 1'b0, 1'b1);
        run_branch(BEQ, 8'h05, 0, 3'b000, 0, 3'b000, 0);
        tests_run++;
        if (pc_out !== 9'h019) begin
            tests_failed++;
            $display("FAIL beq_taken_pc: got %0h expected 19", pc_out);
        end
        apply_reset();
        step_to(9'h013);
        set_flags(1'b0, 1'b0, 1'b0);
        run_branch(BEQ, 8'h05, 0, 3'b000, 0, 3'b000, 0);
        tests_run++;
        if (pc_out !== 9'h014) begin
            tests_failed++;
            $display("FAIL beq_not_taken_pc: got %0h expected 14", pc_out);
        end
    endtask

    task automatic test_blt_ble();
        step_to(9'h020);
        set_flags(1'b1, 1'b0, 1'b0);
        run_branch(BLT, 8'hFE, 0, 3'b000, 0, 3'b000, 0);
        tests_run++;
        if (pc_out !== 9'h01F) begin
            tests_failed++;
            $display("FAIL blt_pc: got %0h expected 1f", pc_out);
        end
        step_to(9'h020);
        set_flags(1'b1, 1'b1, 1'b0);
        run_branch(BLE, 8'h30, 0, 3'b000, 0, 3'b000, 0);
        tests_run++;
        if (pc_out !== 9'h021) begin
            tests_failed++;
            $display("FAIL ble_pc: got %0h expected 21", pc_out);
        end
    endtask

    task automatic test_flag_timing();
        set_flags(1'b0, 1'b0, 1'b0);
        // load Z=1 together with the BNE request; pc_inc noise is dropped throughout
        run_branch(BNE, 8'h10, 1, 3'b001, 0, 3'b000, 1);
        set_flags(1'b0, 1'b0, 1'b1);
        // load Z=0 during EVAL; BEQ still sees Z=1
        run_branch(BEQ, 8'h08, 0, 3'b000, 1, 3'b000, 1);
    endtask

    task automatic test_wrap();
        step_to(9'h1FF);
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        m_pc = 9'h000;
        tests_run++;
        if (pc_out !== 9'h000) begin
            tests_failed++;
            $display("FAIL pc_wrap: got %0h expected 0", pc_out);
        end
        step_to(9'h002);
        run_branch(B, 8'h80, 0, 3'b000, 0, 3'b000, 0);
        tests_run++;
        if (pc_out !== 9'h183) begin
            tests_failed++;
            $display("FAIL neg_wrap: got %0h expected 183", pc_out);
        end
        step_to(9'h1F0);
        run_branch(B, 8'h7F, 0, 3'b000, 0, 3'b000, 0);
        tests_run++;
        if (pc_out !== 9'h070) begin
            tests_failed++;
            $display("FAIL pos_wrap: got %0h expected 70", pc_out);
        end
    endtask

    task automatic test_illegal();
        for (int c = 5; c < 8; c++)
            run_branch(3'(c), 8'h20, 0, 3'b000, 0, 3'b000, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            set_flags(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_branch(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 4; i++)
            run_branch(B, 8'($urandom_range(0, 255)), 0, 3'b000, 0, 3'b000, 0);
        tests_run++;
`ifdef BRANCH_STATS_EN
        if (taken_count !== 16'd4) begin
            tests_failed++;
            $display("FAIL taken_count4: got %0d expected 4", taken_count);
        end
`else
        if (taken_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL taken_count_off: got %0d expected 0", taken_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        step_to(9'h030);
        bif.br_valid = 1'b1; bif.br_cond = B; bif.br_imm8 = 8'h40;
        tick();
        bif.br_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_pc = RST_PC; m_n = 1'b0; m_v = 1'b0; m_z = 1'b0; m_cnt = 0;
        tests_run++;
        if (dbg_state !== IDLE || pc_out !== 9'h010 || bif.done !== 1'b0
            || bif.br_ready !== 1'b1 || taken_count !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_mid: got st=%0d pc=%0h done=%b rdy=%b cnt=%0d expected st=0 pc=10 done=0 rdy=1 cnt=0",
                     dbg_state, pc_out, bif.done, bif.br_ready, taken_count);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (bif.done !== 1'b0 || pc_out !== 9'h010) begin
                tests_failed++;
                $display("FAIL reset_mid_quiet: got done=%b pc=%0h expected done=0 pc=10",
                         bif.done, pc_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pc_inc();
        test_beq();
        test_blt_ble();
        test_flag_timing();
        test_wrap();
        test_illegal();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
